pipe_bus_rx: RTL and testbench

- Receive side of the 25-bit packed pipeline bus: bus[24] = tag, bus[23:8] = data, bus[7:0] = lo8.
- Accepts packed words over a valid/ready handshake and buffers them in a small FIFO.
- Unpacks each word into tag/data/lo8 fields presented on a valid/ready output.
- Checks the redundancy rule lo8 == data[7:0] per word, flags violations, and keeps a sticky error.

---
 rtl/pipe_bus_rx.sv | 130 +++++++++++++
 tb/tb_pipe_bus_rx.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_bus_rx.sv
// pipe_bus_rx: receive side of the 25-bit packed pipeline bus.
// Buffers packed words {tag, data[15:0], lo8[7:0]} in a DEPTH-entry FIFO and
// presents the head word unpacked on a valid/ready output.
// Each word is checked at push time against lo8 == data[7:0]. A mismatch is
// stored with the word and also raises a sticky error flag.
// Optional statistics counters are enabled by defining PIPE_BUS_RX_STATS_EN.
module pipe_bus_rx #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [24:0]   in_bus,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_tag,
  output logic [15:0]   out_data,
  output logic [7:0]    out_lo8,
  output logic          out_err,
  output logic          err_sticky,
  input  logic          err_clr,
  output logic [AW:0]   level
`ifdef PIPE_BUS_RX_STATS_EN
  ,
  output logic [15:0]   rx_count,
  output logic [15:0]   err_count
`endif
);

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Each entry holds {chk_err, packed word}
  logic [25:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          chk_err;
  logic [25:0]   head;

  // Ready depends only on occupancy, so a full FIFO refuses a push even
  // when a pop happens in the same cycle.
  assign in_ready  = (level != LVL_FULL);
  assign out_valid = (level != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign chk_err   = (in_bus[7:0] != in_bus[15:8]);

  // Head entry is read combinationally. When empty this shows stale storage.
  assign head     = mem[rd_ptr];
  assign out_err  = head[25];
  assign out_tag  = head[24];
  assign out_data = head[23:8];
  assign out_lo8  = head[7:0];

  // Storage write. Reset clears every entry so the outputs read zero.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= {chk_err, in_bus};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Occupancy tracks push minus pop, and holds when both happen.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      level <= '0;
    end else begin
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Sticky error. A new error outranks a clear in the same cycle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      err_sticky <= 1'b0;
    end else begin
      err_sticky <= (err_sticky & ~err_clr) | (push & chk_err);
    end
  end

`ifdef PIPE_BUS_RX_STATS_EN
  // Accepted-word counter. It wraps and ignores err_clr.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_count <= '0;
    end else if (push) begin
      rx_count <= rx_count + 16'd1;
    end
  end

  // Error counter. It saturates at all-ones, and err_clr zeroes it.
  // When a clear meets an erroring push, the push counts as the first error.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      err_count <= '0;
    end else if (push && chk_err) begin
      if (err_clr)
        err_count <= 16'd1;
      else if (err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end else if (err_clr) begin
      err_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_bus_rx.sv
// Self-checking bench for pipe_bus_rx. Compares the DUT against a queue-based
// reference model using directed scenarios plus randomized traffic.
module tb_pipe_bus_rx;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [24:0]   in_bus = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_tag;
  logic [15:0]   out_data;
  logic [7:0]    out_lo8;
  logic          out_err;
  logic          err_sticky;
  logic          err_clr = 1'b0;
  logic [AW:0]   level;
`ifdef PIPE_BUS_RX_STATS_EN
  logic [15:0]   rx_count;
  logic [15:0]   err_count;
`endif

  pipe_bus_rx #(.DEPTH(DEPTH)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bus    (in_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .out_data  (out_data),
    .out_lo8   (out_lo8),
    .out_err   (out_err),
    .err_sticky(err_sticky),
    .err_clr   (err_clr),
    .level     (level)
`ifdef PIPE_BUS_RX_STATS_EN
    ,
    .rx_count  (rx_count),
    .err_count (err_count)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a queue of accepted words plus error state.
  logic [24:0] mq[$];
  bit          m_sticky = 1'b0;
  logic [15:0] m_rx   = '0;
  logic [15:0] m_errc = '0;

  function automatic bit word_bad(input logic [24:0] w);
    return w[7:0] != w[15:8];
  endfunction

  // Apply the current inputs for one clock edge, then update the model.
  task automatic tick();
    bit p, q, bad;
    logic [24:0] w;
    p   = in_valid && (mq.size() < DEPTH);
    q   = out_ready && (mq.size() > 0);
    w   = in_bus;
    bad = word_bad(w);
    @(posedge sys_clk);
    #1;
    if (q) void'(mq.pop_front());
    if (p) mq.push_back(w);
    m_sticky = (m_sticky && !err_clr) || (p && bad);
    if (p) m_rx = m_rx + 16'd1;
    if (p && bad) m_errc = err_clr ? 16'd1 : ((m_errc == 16'hFFFF) ? m_errc : m_errc + 16'd1);
    else if (err_clr) m_errc = '0;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || level !== '0 || err_sticky !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: valid=%b ready=%b level=%0d sticky=%b, want 0 1 0 0",
               out_valid, in_ready, level, err_sticky);
    end
    n_vec++;
    if (out_tag !== 1'b0 || out_data !== 16'h0 || out_lo8 !== 8'h0 || out_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_fields: tag=%b data=%h lo8=%h err=%b, want all 0",
               out_tag, out_data, out_lo8, out_err);
    end
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    in_bus = 25'h1123434; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_tag !== 1'b1 || out_data !== 16'h1234 ||
        out_lo8 !== 8'h34 || out_err !== 1'b0 || level !== 3'(1)) begin
      n_err++;
      $display("FAIL single_head: v=%b tag=%b data=%h lo8=%h err=%b lvl=%0d, want 1 1 1234 34 0 1",
               out_valid, out_tag, out_data, out_lo8, out_err, level);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_vec++;
    if (level !== '0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_pop: lvl=%0d v=%b, want 0 0", level, out_valid);
    end
  endtask

  task automatic test_check_err();
    in_bus = 25'h0ABCD00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out_err !== 1'b1 || out_data !== 16'hABCD || out_lo8 !== 8'h00 || err_sticky !== 1'b1) begin
      n_err++;
      $display("FAIL chk_head: err=%b data=%h lo8=%h sticky=%b, want 1 abcd 00 1",
               out_err, out_data, out_lo8, err_sticky);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_vec++;
    if (err_sticky !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL chk_sticky_hold: sticky=%b v=%b, want 1 0", err_sticky, out_valid);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_vec++;
    if (err_sticky !== 1'b0) begin
      n_err++;
      $display("FAIL chk_clear: sticky=%b, want 0", err_sticky);
    end
  endtask

  task automatic test_full_wrap();
    logic [24:0] w;
    int k;
    out_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      w = {1'b0, 8'h00, 8'(i), 8'(i)};
      in_bus = w; in_valid = 1'b1;
      tick();
    end
    n_vec++;
    if (in_ready !== 1'b0 || level !== 3'(DEPTH)) begin
      n_err++;
      $display("FAIL full_flag: ready=%b lvl=%0d, want 0 %0d", in_ready, level, DEPTH);
    end
    in_bus = {1'b1, 8'h00, 8'h55, 8'h55}; in_valid = 1'b1;
    tick();
    n_vec++;
    if (level !== 3'(DEPTH) || out_data !== 16'h0001) begin
      n_err++;
      $display("FAIL full_refuse: lvl=%0d head=%h, want %0d 0001", level, out_data, DEPTH);
    end
    // Drain six words while offering new words each cycle.
    k = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w = {1'b0, 8'h00, 8'(8'h10 + i), 8'(8'h10 + i)};
      in_bus = w; in_valid = 1'b1;
      n_vec++;
      if (out_valid !== 1'b1 || {out_tag, out_data, out_lo8} !== mq[0]) begin
        n_err++;
        $display("FAIL wrap_order[%0d]: v=%b got=%h, want 1 %h", k, out_valid,
                 {out_tag, out_data, out_lo8}, mq[0]);
      end
      k++;
      tick();
    end
    in_valid = 1'b0;
    n_vec++;
    if (level !== 3'(mq.size())) begin
      n_err++;
      $display("FAIL wrap_level: lvl=%0d, want %0d", level, mq.size());
    end
    drain();
  endtask

  task automatic test_concurrent();
    in_bus = 25'h0AAAAAA; in_valid = 1'b1;
    tick();
    in_bus = 25'h1BBBBBB; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    idle_inputs();
    n_vec++;
    if (level !== 3'(1) || out_valid !== 1'b1 || {out_tag, out_data, out_lo8} !== 25'h1BBBBBB) begin
      n_err++;
      $display("FAIL concurrent: lvl=%0d v=%b head=%h, want 1 1 1bbbbbb",
               level, out_valid, {out_tag, out_data, out_lo8});
    end
    drain();
  endtask

  task automatic test_clr_set();
    logic [15:0] rx_before;
    rx_before = m_rx;
    in_bus = 25'h0123400; in_valid = 1'b1; err_clr = 1'b1;
    tick();
    idle_inputs();
    n_vec++;
    if (err_sticky !== 1'b1) begin
      n_err++;
      $display("FAIL clr_set_sticky: sticky=%b, want 1", err_sticky);
    end
`ifdef PIPE_BUS_RX_STATS_EN
    n_vec++;
    if (err_count !== 16'd1 || rx_count !== rx_before + 16'd1) begin
      n_err++;
      $display("FAIL clr_set_stats: errc=%0d rx=%0d, want 1 %0d", err_count, rx_count, rx_before + 16'd1);
    end
`endif
    drain();
  endtask

  task automatic test_random();
    logic [24:0] w;
    for (int c = 0; c < 400; c++) begin
      w = 25'($urandom);
      if ($urandom_range(1, 0) == 0) w[7:0] = w[15:8];
      in_bus    = w;
      in_valid  = ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(2, 0) != 0);
      err_clr   = ($urandom_range(7, 0) == 0);
      tick();
      n_vec++;
      if (level !== 3'(mq.size()) || out_valid !== (mq.size() != 0) ||
          in_ready !== (mq.size() != DEPTH) || err_sticky !== m_sticky) begin
        n_err++;
        $display("FAIL rand_ctrl[%0d]: lvl=%0d v=%b r=%b st=%b, want %0d %b %b %b", c,
                 level, out_valid, in_ready, err_sticky, mq.size(), mq.size() != 0,
                 mq.size() != DEPTH, m_sticky);
      end
      if (mq.size() != 0) begin
        n_vec++;
        if ({out_tag, out_data, out_lo8} !== mq[0] || out_err !== word_bad(mq[0])) begin
          n_err++;
          $display("FAIL rand_head[%0d]: got=%h err=%b, want %h %b", c,
                   {out_tag, out_data, out_lo8}, out_err, mq[0], word_bad(mq[0]));
        end
      end
`ifdef PIPE_BUS_RX_STATS_EN
      n_vec++;
      if (rx_count !== m_rx || err_count !== m_errc) begin
        n_err++;
        $display("FAIL rand_stats[%0d]: rx=%0d errc=%0d, want %0d %0d", c, rx_count, err_count, m_rx, m_errc);
      end
`endif
    end
    drain();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      in_bus = {1'b0, 8'h00, 8'hE0 + 8'(i), 8'h00}; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n_vec++;
    if (level !== 3'(3) || err_sticky !== 1'b1) begin
      n_err++;
      $display("FAIL areset_pre: lvl=%0d sticky=%b, want 3 1", level, err_sticky);
    end
    #3;
    sys_rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || level !== '0 || err_sticky !== 1'b0) begin
      n_err++;
      $display("FAIL areset_now: v=%b r=%b lvl=%0d st=%b, want 0 1 0 0",
               out_valid, in_ready, level, err_sticky);
    end
`ifdef PIPE_BUS_RX_STATS_EN
    n_vec++;
    if (rx_count !== 16'd0 || err_count !== 16'd0) begin
      n_err++;
      $display("FAIL areset_stats: rx=%0d errc=%0d, want 0 0", rx_count, err_count);
    end
`endif
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    mq.delete();
    m_sticky = 1'b0; m_rx = '0; m_errc = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || level !== '0 || out_data !== 16'h0) begin
      n_err++;
      $display("FAIL areset_quiet: v=%b lvl=%0d data=%h, want 0 0 0000", out_valid, level, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_check_err();
    test_full_wrap();
    test_concurrent();
    test_clr_set();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
